seq_alu: RTL



---
 rtl/seq_alu.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Execute stage behind the register file: one-cycle logic/add ops, iterative
// shift-add multiply and one-bit-per-cycle shifts, plus the NZP register.
//
// state  | meaning
// IDLE   | waiting for Start; simple ops and shift-by-0 finish on the accepting edge
// MUL    | shift-add multiply, one multiplier bit per cycle
// SHIFT  | shift the working value one bit per cycle
// DONE   | result valid on ALU_OUT, Done pulses for this one cycle
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       ALUK,
  input  logic [WIDTH-1:0] SR1_IN,
  input  logic [WIDTH-1:0] SR2_IN,
  input  logic [4:0]       IMM5,
  input  logic             SR2MUX,
  input  logic             LD_CC,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             N,
  output logic             Z,
  output logic             P
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;

  state_t           state;
  logic [2:0]       op;
  logic             cc_en;
  logic [4:0]       count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] work;

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] work_step;

  assign a_in = SR1_IN;
  assign b_in = SR2MUX ? {{(WIDTH-5){IMM5[4]}}, IMM5} : SR2_IN;

  always_comb begin
    simple_res = a_in;
    case (ALUK[1:0])
      2'b00:   simple_res = a_in + b_in;
      2'b01:   simple_res = a_in & b_in;
      2'b10:   simple_res = ~a_in;
      default: simple_res = a_in;
    endcase
  end

  assign acc_step = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    work_step = work;
    case (op)
      OP_SHL:  work_step = work << 1;
      OP_SHR:  work_step = work >> 1;
      default: work_step = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

  function automatic logic [2:0] cc_of(input logic [WIDTH-1:0] r);
    if (r[WIDTH-1])   return 3'b100;
    else if (r == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      ALU_OUT   <= '0;
      Done      <= 1'b0;
      Busy      <= 1'b0;
      {N, Z, P} <= 3'b010;
      op        <= 3'b000;
      cc_en     <= 1'b0;
      count     <= 5'd0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      work      <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            op    <= ALUK;
            cc_en <= LD_CC;
            if (!ALUK[2]) begin
              ALU_OUT <= simple_res;
              if (LD_CC) {N, Z, P} <= cc_of(simple_res);
              Done  <= 1'b1;
              state <= S_DONE;
            end else if (ALUK == OP_MUL) begin
              acc    <= '0;
              mcand  <= a_in;
              mplier <= b_in;
              count  <= 5'd16;
              Busy   <= 1'b1;
              state  <= S_MUL;
            end else if (b_in[3:0] == 4'd0) begin
              ALU_OUT <= a_in;
              if (LD_CC) {N, Z, P} <= cc_of(a_in);
              Done  <= 1'b1;
              state <= S_DONE;
            end else begin
              work  <= a_in;
              count <= {1'b0, b_in[3:0]};
              Busy  <= 1'b1;
              state <= S_SHIFT;
            end
          end
        end

        S_MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 5'd1;
          // count==1 here means this edge retires the final multiplier bit
          if (count == 5'd1) begin
            ALU_OUT <= acc_step;
            if (cc_en) {N, Z, P} <= cc_of(acc_step);
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_SHIFT: begin
          work  <= work_step;
          count <= count - 5'd1;
          if (count == 5'd1) begin
            ALU_OUT <= work_step;
            if (cc_en) {N, Z, P} <= cc_of(work_step);
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_DONE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
